pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives stall_i/flush_i
//  of PC and the IF2ID, ID2EX, EX2MEM, MEM2WB pipeline registers. Resolves load-use,
//  multi-cycle divide, fetch/data memory wait and exception/ERET redirect.
//  Sits beside the datapath; purely control, no data.
// PARAMETERS
//  CNT_W  32  width of saturating stall-cycle performance counter
// PORTS
//  clk_i           in   1      clock, all state updates on posedge
//  rst_i           in   1      reset, asynchronous, active-low (0 = reset)
//  id_load_use_i   in   1      ID instr sources EX load result
//  ex_is_div_i     in   1      valid DIV/DIVU in EX
//  div_done_i      in   1      divider result valid, 1-cycle pulse
//  if_busy_i       in   1      instruction fetch not yet returned
//  mem_busy_i      in   1      data access in MEM not yet returned
//  exc_valid_i     in   1      exception or ERET committed in MEM
//  stall_o         out  5      hold: [0]PC [1]IF2ID [2]ID2EX [3]EX2MEM [4]MEM2WB
//  flush_o         out  5      bubble, same bit mapping ([0] always 0)
//  redirect_o      out  1      PC loads exception/EPC target this cycle
//  div_start_o     out  1      start divider, 1-cycle pulse
//  div_cancel_o    out  1      abort divider, 1-cycle pulse
//  stall_cnt_o     out  CNT_W  cycles with stall_o[0]=1, saturating
// BEHAVIOUR
//  - FSM states: RUN, DIV_BUSY, DIV_HOLD, EXC_WAIT. Reset -> RUN, counter 0.
//    While rst_i=0 all outputs 0. Outputs combinational from state+inputs.
//  - Stall/flush patterns (stall,flush), highest priority first:
//    EXC  : exc_valid_i or EXC_WAIT -> see below
//    MEM  : mem_busy_i                 -> 5'b01111, 5'b10000
//    DIV  : div stall (below)          -> 5'b00111, 5'b01000
//    IF   : if_busy_i                  -> 5'b00001, 5'b00010
//    LU   : id_load_use_i              -> 5'b00011, 5'b00100
//    none -> 0, 0. Only the winner's pattern drives the outputs.
//  - Divide sequencing:
//    RUN & ex_is_div_i & no exc: div_start_o=1, DIV stall, -> DIV_BUSY.
//    DIV_BUSY & !div_done_i: DIV stall. & div_done_i: no DIV stall;
//      if mem_busy_i same cycle (EX frozen) -> DIV_HOLD else -> RUN.
//    DIV_HOLD: no DIV stall, no restart; -> RUN on first cycle with mem_busy_i=0.
//    Prevents re-issue of the same divide when EX was frozen at completion.
//  - Exception (exc_valid_i, any state):
//    if_busy_i=0: stall 0, flush 5'b11110, redirect_o=1, -> RUN.
//    if_busy_i=1: stall 5'b00001, flush 5'b11110, redirect_o=0, -> EXC_WAIT.
//    EXC_WAIT: stall 5'b00001, flush 5'b11110 each cycle until if_busy_i=0;
//      that cycle stall 0, flush 5'b11110, redirect_o=1, -> RUN.
//    exc_valid_i beats mem_busy_i (excepting instr performs no access).
//    In DIV_BUSY/DIV_HOLD: div_cancel_o=1 for that cycle. Divide in EX is flushed.
//    Never div_start_o in a cycle with exc_valid_i or in EXC_WAIT.
//  - exc_valid_i while in EXC_WAIT: absorbed, single redirect only.
//  - div_done_i outside DIV_BUSY: ignored.
//  - stall_cnt_o += 1 each cycle stall_o[0]=1; holds at all-ones.
//  - Async reset mid-divide or mid-EXC_WAIT: immediately RUN, no cancel pulse.
// TESTING
//  1 id_load_use_i=1 one cycle -> stall=00011, flush=00100; next cycle 0/0.
//  2 ex_is_div_i=1, div_done_i after 8 cycles -> div_start_o pulse at cycle 0,
//    stall=00111 for cycles 0-8, released on done cycle, stall_cnt_o=9.
//  3 div_done_i with mem_busy_i=1 for 3 cycles -> DIV_HOLD, stall=01111,
//    no 2nd div_start_o while ex_is_div_i stays 1.
//  4 exc_valid_i with if_busy_i=1 for 2 cycles -> flush=11110, stall=00001 x2,
//    redirect_o=1 on 3rd cycle only.
//  5 exc_valid_i during DIV_BUSY -> div_cancel_o=1, flush=11110, redirect_o=1,
//    state RUN, no stall next cycle.
//  6 mem_busy_i & id_load_use_i & if_busy_i together -> 01111/10000;
//    stall_cnt_o saturates at 2^CNT_W-1 (force CNT_W=4: holds at 15).

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, multi-cycle divide,
// fetch/data memory wait and exception/ERET redirect, plus a stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_load_use_i,
  input  logic             ex_is_div_i,
  input  logic             div_done_i,
  input  logic             if_busy_i,
  input  logic             mem_busy_i,
  input  logic             exc_valid_i,
  output logic [4:0]       stall_o,
  output logic [4:0]       flush_o,
  output logic             redirect_o,
  output logic             div_start_o,
  output logic             div_cancel_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_HOLD = 2'd2,
    EXC_WAIT = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_stallCnt;
  logic [4:0]       w_stall;
  logic [4:0]       w_flush;
  logic             w_redirect;
  logic             w_divStart;
  logic             w_divCancel;
  logic             w_divStall;
  logic             w_excActive;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Divide sequencing first, then the exception path overrides it; the
  // stall/flush outputs come from the single highest-priority hazard.
  always_comb begin
    w_nextState = r_state;
    w_stall     = 5'b00000;
    w_flush     = 5'b00000;
    w_redirect  = 1'b0;
    w_divStart  = 1'b0;
    w_divCancel = 1'b0;
    w_divStall  = 1'b0;
    w_excActive = exc_valid_i || (r_state == EXC_WAIT);

    case (r_state)
      RUN: begin
        if (ex_is_div_i) begin
          w_divStart  = 1'b1;
          w_divStall  = 1'b1;
          w_nextState = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (!div_done_i) begin
          w_divStall = 1'b1;
        end else if (mem_busy_i) begin
          // EX is frozen on completion; park so the same divide is not re-issued
          w_nextState = DIV_HOLD;
        end else begin
          w_nextState = RUN;
        end
      end
      DIV_HOLD: begin
        if (!mem_busy_i) begin
          w_nextState = RUN;
        end
      end
      default: ;
    endcase

    if (w_excActive) begin
      w_divStart  = 1'b0;
      w_divStall  = 1'b0;
      w_divCancel = exc_valid_i && ((r_state == DIV_BUSY) || (r_state == DIV_HOLD));
      w_flush     = 5'b11110;
      if (if_busy_i) begin
        w_stall     = 5'b00001;
        w_nextState = EXC_WAIT;
      end else begin
        w_redirect  = 1'b1;
        w_nextState = RUN;
      end
    end else if (mem_busy_i) begin
      w_stall = 5'b01111;
      w_flush = 5'b10000;
    end else if (w_divStall) begin
      w_stall = 5'b00111;
      w_flush = 5'b01000;
    end else if (if_busy_i) begin
      w_stall = 5'b00001;
      w_flush = 5'b00010;
    end else if (id_load_use_i) begin
      w_stall = 5'b00011;
      w_flush = 5'b00100;
    end
  end

  // Saturating count of cycles in which the PC is held
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stallCnt <= '0;
    end else if (w_stall[0] && (r_stallCnt != {CNT_W{1'b1}})) begin
      r_stallCnt <= r_stallCnt + CNT_W'(1);
    end
  end

  assign stall_o      = rst_i ? w_stall     : 5'b00000;
  assign flush_o      = rst_i ? w_flush     : 5'b00000;
  assign redirect_o   = rst_i ? w_redirect  : 1'b0;
  assign div_start_o  = rst_i ? w_divStart  : 1'b0;
  assign div_cancel_o = rst_i ? w_divCancel : 1'b0;
  assign stall_cnt_o  = rst_i ? r_stallCnt  : '0;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; counter narrowed to 4 bits so
// saturation is reachable quickly.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rstN;
  logic             loadUse;
  logic             isDiv;
  logic             divDone;
  logic             ifBusy;
  logic             memBusy;
  logic             excValid;
  logic [4:0]       stall;
  logic [4:0]       flush;
  logic             redirect;
  logic             divStart;
  logic             divCancel;
  logic [CNT_W-1:0] stallCnt;

  int vectorCount;
  int missCount;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rstN),
    .id_load_use_i(loadUse),
    .ex_is_div_i  (isDiv),
    .div_done_i   (divDone),
    .if_busy_i    (ifBusy),
    .mem_busy_i   (memBusy),
    .exc_valid_i  (excValid),
    .stall_o      (stall),
    .flush_o      (flush),
    .redirect_o   (redirect),
    .div_start_o  (divStart),
    .div_cancel_o (divCancel),
    .stall_cnt_o  (stallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later
  task automatic applyStimulus(input logic lu, input logic dv, input logic dn,
                               input logic ifb, input logic mb, input logic ex);
    @(negedge clk);
    loadUse  = lu;
    isDiv    = dv;
    divDone  = dn;
    ifBusy   = ifb;
    memBusy  = mb;
    excValid = ex;
    #1;
  endtask

  task automatic checkVec(input string tag, input logic [4:0] expStall,
                          input logic [4:0] expFlush, input logic expRedir,
                          input logic expStart, input logic expCancel);
    checkOutput({tag, ".stall"},  32'(stall),     32'(expStall));
    checkOutput({tag, ".flush"},  32'(flush),     32'(expFlush));
    checkOutput({tag, ".redir"},  32'(redirect),  32'(expRedir));
    checkOutput({tag, ".start"},  32'(divStart),  32'(expStart));
    checkOutput({tag, ".cancel"}, 32'(divCancel), 32'(expCancel));
  endtask

  // Reset with hazards asserted: every output must still read zero
  task automatic doReset();
    @(negedge clk);
    rstN     = 1'b0;
    loadUse  = 1'b1;
    isDiv    = 1'b1;
    divDone  = 1'b0;
    ifBusy   = 1'b0;
    memBusy  = 1'b1;
    excValid = 1'b0;
    #1;
    checkVec("reset", 5'b00000, 5'b00000, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.cnt", 32'(stallCnt), 32'd0);
    @(negedge clk);
    rstN     = 1'b1;
    loadUse  = 1'b0;
    isDiv    = 1'b0;
    memBusy  = 1'b0;
  endtask

  initial begin
    vectorCount = 0;
    missCount   = 0;
    rstN        = 1'b0;
    loadUse     = 1'b0;
    isDiv       = 1'b0;
    divDone     = 1'b0;
    ifBusy      = 1'b0;
    memBusy     = 1'b0;
    excValid    = 1'b0;

    // Load-use: one bubble then clear
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkVec("lu", 5'b00011, 5'b00100, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkVec("lu.after", 5'b00000, 5'b00000, 0, 0, 0);
    checkOutput("lu.cnt", 32'(stallCnt), 32'd1);

    // Divide: 9 stalled cycles, release on done, counter 9
    doReset();
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkVec("div.c0", 5'b00111, 5'b01000, 0, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkVec($sformatf("div.c%0d", i), 5'b00111, 5'b01000, 0, 0, 0);
    end
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkVec("div.done", 5'b00000, 5'b00000, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("div.cnt", 32'(stallCnt), 32'd9);
    checkVec("div.idle", 5'b00000, 5'b00000, 0, 0, 0);

    // Divide completes under mem stall: hold, no re-issue
    doReset();
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkVec("hold.c0", 5'b00111, 5'b01000, 0, 1, 0);
    applyStimulus(0, 1, 1, 0, 1, 0);
    checkVec("hold.done", 5'b01111, 5'b10000, 0, 0, 0);
    for (int i = 2; i <= 3; i++) begin
      applyStimulus(0, 1, 0, 0, 1, 0);
      checkVec($sformatf("hold.c%0d", i), 5'b01111, 5'b10000, 0, 0, 0);
    end
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkVec("hold.release", 5'b00000, 5'b00000, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkVec("hold.idle", 5'b00000, 5'b00000, 0, 0, 0);

    // Exception with fetch outstanding; divide in EXC_WAIT must not start
    doReset();
    applyStimulus(0, 0, 0, 1, 0, 1);
    checkVec("exc.c0", 5'b00001, 5'b11110, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0);
    checkVec("exc.c1", 5'b00001, 5'b11110, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkVec("exc.c2", 5'b00000, 5'b11110, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkVec("exc.c3", 5'b00000, 5'b00000, 0, 0, 0);

    // Exception during divide: cancel and redirect together
    doReset();
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkVec("cancel.c0", 5'b00111, 5'b01000, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkVec("cancel.exc", 5'b00000, 5'b11110, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkVec("cancel.after", 5'b00000, 5'b00000, 0, 0, 0);

    // Combined hazards: mem wins; counter saturates at 15; exc beats mem
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 0, 1, 1, 0);
      checkOutput($sformatf("combo.stall%0d", i), 32'(stall), 32'h0f);
      checkOutput($sformatf("combo.flush%0d", i), 32'(flush), 32'h10);
      if (i == 15) checkOutput("combo.cnt15", 32'(stallCnt), 32'd15);
    end
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkVec("combo.exc", 5'b00000, 5'b11110, 1, 0, 0);
    checkOutput("combo.cntSat", 32'(stallCnt), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
